jam_perm_search: RTL
====================

// Module: jam_perm_search
// PURPOSE
//  Exhaustive job-assignment engine: N workers, N jobs. Walks all N! permutations in
//  lexicographic order, fetches each worker/job cost from an external cost table,
//  and reports the minimum total cost, how many permutations reach it, and the first
//  optimal assignment. Start/done handshake allows repeated runs without reset.
// PARAMETERS
//  N         8   workers = jobs (2..8)
//  IDXW      3   index width, = clog2(N)
//  COSTW     7   width of one Cost entry
//  SUMW      10  total-cost width; must hold N*(2^COSTW-1)
//  CNTW      16  MatchCount width; count saturates at all-ones
//  COST_LAT  1   cycles from W/J driven to Cost valid (1..4)
// PORTS
//  CLK         in   1          clock, rising edge
//  RST         in   1          reset, asynchronous, active-high
//  start       in   1          pulse; begins a run when idle
//  busy        out  1          high from accepted start until Valid rises
//  W           out  IDXW       worker index of cost lookup
//  J           out  IDXW       job index of cost lookup
//  Cost        in   COSTW      cost[W][J], valid COST_LAT cycles after W/J
//  MatchCount  out  CNTW       number of permutations with total == MinCost
//  MinCost     out  SUMW       minimum total cost found
//  BestPerm    out  N*IDXW     BestPerm[i*IDXW+:IDXW] = job of worker i, first optimum
//  Valid       out  1          results final; held until next accepted start
// BEHAVIOUR
//  - Reset: all outputs 0 except MinCost = all-ones; FSM -> IDLE; perm = identity.
//  - RST mid-run aborts immediately; no partial results kept; Valid stays 0.
//  - start sampled only in IDLE/DONE; ignored while busy. Accept: Valid<=0, busy<=1,
//    perm<=identity, MinCost<=all-ones, MatchCount<=0, BestPerm<=0.
//  - States: IDLE, ISSUE, DRAIN, COMPARE, PIVOT, SUCC, SWAP, REV, DONE.
//  - ISSUE: N cycles; cycle i drives W=i, J=perm[i]. Sum accumulator (SUMW, zero-
//    extended adds, no overflow by parameter rule) adds Cost COST_LAT cycles later.
//  - DRAIN: COST_LAT cycles until last Cost summed. W/J hold last value.
//  - COMPARE (1 cycle): first permutation of run, or sum < MinCost -> MinCost=sum,
//    MatchCount=1, BestPerm=perm. sum == MinCost -> MatchCount+1, saturating.
//    Sum cleared for next permutation.
//  - PIVOT: p from N-2 downward, one index/cycle, until perm[p] < perm[p+1].
//    No pivot after p=0 -> DONE (last permutation evaluated).
//  - SUCC: k from N-1 downward, one/cycle, stop at first perm[k] > perm[p].
//  - SWAP (1 cycle): exchange perm[p], perm[k].
//  - REV: reverse perm[p+1..N-1], one pair swap/cycle, floor((N-1-p)/2) cycles;
//    zero pairs -> skip straight to ISSUE. Then ISSUE next permutation.
//  - DONE: Valid=1, busy=0; outputs held; new start re-runs.
//  - Exactly N! COMPARE cycles per run; Cost sampled only in ISSUE/DRAIN windows.
// STRUCTURE
//  - jam_pkg: state encodings, clog2 function, perm index/count width helpers.
//  - Sub-module jam_perm_step: holds perm register array; req/ack next-permutation
//    engine (PIVOT..REV) returning ack + last flag; top keeps issue, sum, compare.
// TESTING
//  - N=3, cost=0 if W==J else 5 -> MinCost=0, MatchCount=1, BestPerm={2,1,0} (w2..w0).
//  - N=4, all Cost=1 -> MinCost=4, MatchCount=24, BestPerm=identity, 24 COMPAREs.
//  - N=8, CNTW=8, all Cost=3 -> MinCost=24, MatchCount=255 (saturated).
//  - N=4, COST_LAT=3, cost[w][j]=(w+2j)%7 -> results identical to COST_LAT=1 run.
//  - start pulsed mid-run ignored; RST mid-run -> Valid=0, MinCost=all-ones; rerun ok.
//  - Back-to-back runs with different tables: Valid drops on start, 2nd result correct.

Source files
------------

// File: rtl/jam_perm_search_pkg.sv
// Shared state encodings and width helpers for the exhaustive assignment engine.
package jam_perm_search_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_COMPARE,
      ST_PIVOT,
      ST_SUCC,
      ST_SWAP,
      ST_REV,
      ST_DONE
   } jam_state_e;

   localparam int JAM_MAX_N = 8;

   function automatic int jam_clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // Bits needed to count all n! permutations of one run.
   function automatic int jam_perm_cnt_w(input int n);
      int f;
      f = 1;
      for (int i = 2; i <= n; i++) f = f * i;
      return jam_clog2(f + 1);
   endfunction

endpackage

// File: rtl/jam_perm_search_step.sv
// Permutation register plus next-lexicographic-permutation engine (req/ack).
// state    | meaning
// IDLE     | waiting for req; p preloaded to N-2
// PIVOT    | scan p downward for perm[p] < perm[p+1]; none at p=0 -> ack+last
// SUCC     | scan k downward for first perm[k] > perm[p]
// SWAP     | exchange perm[p], perm[k]; ack when the tail has no pairs
// REV      | reverse tail perm[p+1..N-1], one pair per cycle
module jam_perm_search_step
   import jam_perm_search_pkg::*;
#(
   parameter int N    = 8,
   parameter int IDXW = 3
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              init,
   input  logic              req,
   input  logic [IDXW-1:0]   rd_idx,
   output logic [IDXW-1:0]   rd_job,
   output logic [N*IDXW-1:0] perm_flat,
   output logic              ack,
   output logic              last
);

   localparam logic [IDXW-1:0] TOP_IDX   = IDXW'(N - 1);
   localparam logic [IDXW-1:0] PIV_START = IDXW'(N - 2);

   jam_state_e      state, state_n;
   logic [IDXW-1:0] perm [N];
   logic [IDXW-1:0] p, k, lo, hi;
   logic            is_pivot, is_succ, rev_end;

   assign is_pivot = perm[p] < perm[p + IDXW'(1)];
   assign is_succ  = perm[k] > perm[p];
   assign rev_end  = ({1'b0, hi} - {1'b0, lo}) <= (IDXW + 1)'(2);
   assign rd_job   = perm[rd_idx];

   always_comb begin
      perm_flat = '0;
      for (int i = 0; i < N; i++) perm_flat[i*IDXW +: IDXW] = perm[i];
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)       state <= ST_IDLE;
      else if (init) state <= ST_IDLE;
      else           state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE:  if (req) state_n = ST_PIVOT;
         ST_PIVOT: begin
            if (is_pivot)     state_n = ST_SUCC;
            else if (p == '0) state_n = ST_IDLE;
         end
         ST_SUCC:  if (is_succ) state_n = ST_SWAP;
         ST_SWAP:  state_n = (p == PIV_START) ? ST_IDLE : ST_REV;
         ST_REV:   if (rev_end) state_n = ST_IDLE;
         default:  state_n = ST_IDLE;
      endcase
   end

   always_comb begin
      ack  = 1'b0;
      last = 1'b0;
      case (state)
         ST_PIVOT: begin
            if (!is_pivot && p == '0) begin
               ack  = 1'b1;
               last = 1'b1;
            end
         end
         ST_SWAP: ack = (p == PIV_START);
         ST_REV:  ack = rev_end;
         default: ;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < N; i++) perm[i] <= IDXW'(i);
         p  <= '0;
         k  <= '0;
         lo <= '0;
         hi <= '0;
      end else if (init) begin
         for (int i = 0; i < N; i++) perm[i] <= IDXW'(i);
      end else begin
         case (state)
            ST_IDLE:  p <= PIV_START;
            ST_PIVOT: begin
               if (is_pivot) k <= TOP_IDX;
               else          p <= p - IDXW'(1);
            end
            ST_SUCC:  if (!is_succ) k <= k - IDXW'(1);
            ST_SWAP: begin
               perm[p] <= perm[k];
               perm[k] <= perm[p];
               lo      <= p + IDXW'(1);
               hi      <= TOP_IDX;
            end
            ST_REV: begin
               perm[lo] <= perm[hi];
               perm[hi] <= perm[lo];
               lo       <= lo + IDXW'(1);
               hi       <= hi - IDXW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/jam_perm_search.sv
// Exhaustive N-worker/N-job assignment search: issues cost lookups per permutation,
// sums them, and tracks minimum total, match count and first optimal permutation.
// state    | meaning
// IDLE     | after reset; waits for start
// ISSUE    | N cycles driving W=i, J=perm[i]
// DRAIN    | COST_LAT cycles letting the last Cost reach the sum
// COMPARE  | update MinCost/MatchCount/BestPerm, clear sum
// PIVOT    | step engine walking PIVOT..REV to the next permutation
// DONE     | results valid and held; start re-runs
module jam_perm_search
   import jam_perm_search_pkg::*;
#(
   parameter int N        = 8,
   parameter int IDXW     = 3,
   parameter int COSTW    = 7,
   parameter int SUMW     = 10,
   parameter int CNTW     = 16,
   parameter int COST_LAT = 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              start,
   output logic              busy,
   output logic [IDXW-1:0]   W,
   output logic [IDXW-1:0]   J,
   input  logic [COSTW-1:0]  Cost,
   output logic [CNTW-1:0]   MatchCount,
   output logic [SUMW-1:0]   MinCost,
   output logic [N*IDXW-1:0] BestPerm,
   output logic              Valid
);

   localparam int              DRW      = jam_clog2(COST_LAT + 1);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

   jam_state_e        state, state_n;
   logic [IDXW-1:0]   issue_idx;
   logic [DRW-1:0]    drain_cnt;
   logic [COST_LAT-1:0] cost_vld;
   logic [SUMW-1:0]   sum;
   logic              first;
   logic              accept, issue_en, step_req, step_ack, step_last;
   logic [N*IDXW-1:0] perm_flat;

   jam_perm_search_step #(.N(N), .IDXW(IDXW)) u_step (
      .CLK       (CLK),
      .RST       (RST),
      .init      (accept),
      .req       (step_req),
      .rd_idx    (issue_idx),
      .rd_job    (J),
      .perm_flat (perm_flat),
      .ack       (step_ack),
      .last      (step_last)
   );

   assign W = issue_idx;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= ST_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE, ST_DONE: if (start) state_n = ST_ISSUE;
         ST_ISSUE:   if (issue_idx == LAST_IDX) state_n = ST_DRAIN;
         ST_DRAIN:   if (drain_cnt == '0) state_n = ST_COMPARE;
         ST_COMPARE: state_n = ST_PIVOT;
         ST_PIVOT:   if (step_ack) state_n = step_last ? ST_DONE : ST_ISSUE;
         default:    state_n = ST_IDLE;
      endcase
   end

   always_comb begin
      accept   = start && (state == ST_IDLE || state == ST_DONE);
      issue_en = (state == ST_ISSUE);
      step_req = (state == ST_COMPARE);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         issue_idx  <= '0;
         drain_cnt  <= '0;
         cost_vld   <= '0;
         sum        <= '0;
         first      <= 1'b0;
         busy       <= 1'b0;
         Valid      <= 1'b0;
         MinCost    <= '1;
         MatchCount <= '0;
         BestPerm   <= '0;
      end else begin
         // Lookup-valid pipeline: one bit per issued W/J, aligned with Cost.
         cost_vld <= COST_LAT'({cost_vld, issue_en});
         if (accept) begin
            Valid      <= 1'b0;
            busy       <= 1'b1;
            MinCost    <= '1;
            MatchCount <= '0;
            BestPerm   <= '0;
            first      <= 1'b1;
            sum        <= '0;
            issue_idx  <= '0;
         end
         if (issue_en) begin
            if (issue_idx == LAST_IDX) drain_cnt <= DRW'(COST_LAT - 1);
            else                       issue_idx <= issue_idx + IDXW'(1);
         end
         if (state == ST_DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - DRW'(1);
         if (cost_vld[COST_LAT-1]) sum <= sum + SUMW'(Cost);
         if (state == ST_COMPARE) begin
            sum   <= '0;
            first <= 1'b0;
            if (first || sum < MinCost) begin
               MinCost    <= sum;
               MatchCount <= CNTW'(1);
               BestPerm   <= perm_flat;
            end else if (sum == MinCost && MatchCount != '1) begin
               MatchCount <= MatchCount + CNTW'(1);
            end
         end
         if (state == ST_PIVOT && step_ack) begin
            if (step_last) begin
               Valid <= 1'b1;
               busy  <= 1'b0;
            end else begin
               issue_idx <= '0;
            end
         end
      end
   end

endmodule
